// File: rtl/mem_arbiter.sv
// Arbitrates NUM_CH cache request channels onto one tagged memory bus and routes each returning
// tag to the channel that owns it. Define MEM_ARB_RR_EN for round-robin grants (default: fixed).
module mem_arbiter #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned XLEN   = 64
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_CH-1:0][1:0]            ch_command,
    input  logic [NUM_CH-1:0][XLEN-1:0]       ch_addr,
    input  logic [NUM_CH-1:0][63:0]           ch_data,
    output logic [NUM_CH-1:0]                 ch_grant,
    output logic [NUM_CH-1:0]                 ch_reject,
    output logic [NUM_CH-1:0][TAG_W-1:0]      ch_response,
    output logic [NUM_CH-1:0][TAG_W-1:0]      ch_tag,
    output logic [63:0]                       ch_rdata,
    output logic [XLEN-1:0]                   cache2mem_addr,
    output logic [1:0]                        cache2mem_command,
    output logic [63:0]                       cache2mem_data,
    input  logic [TAG_W-1:0]                  mem2cache_response,
    input  logic [TAG_W-1:0]                  mem2cache_tag,
    input  logic [63:0]                       mem2cache_data,
    output logic [TAG_W:0]                    outstanding,
    output logic                              tag_error
);
    localparam int unsigned CH_W    = $clog2(NUM_CH);
    localparam int unsigned ENTRIES = 1 << TAG_W;
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    logic [ENTRIES-1:0]           valid_q, valid_d;
    logic [ENTRIES-1:0][CH_W-1:0] owner_q, owner_d;
    logic                         tag_error_q;
    logic [NUM_CH-1:0]            req;
    logic                         gnt_any;
    logic [CH_W-1:0]              gnt_idx;
    logic                         accepted, alloc, ret_hit, ret_miss, alloc_conflict;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) req[i] = (ch_command[i] != BUS_NONE);
    end

`ifdef MEM_ARB_RR_EN
    logic [CH_W-1:0] ptr_q, ptr_d;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = (32'(ptr_q) + k) % NUM_CH;
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = CH_W'(idx);
            end
        end
    end

    assign ptr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
`else
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_any = 1'b1;
                gnt_idx = CH_W'(i);
            end
        end
    end
`endif

    always_comb begin
        ch_grant          = '0;
        ch_reject         = '0;
        ch_response       = '0;
        ch_tag            = '0;
        cache2mem_command = BUS_NONE;
        cache2mem_addr    = '0;
        cache2mem_data    = '0;
        if (gnt_any) begin
            ch_grant[gnt_idx]    = 1'b1;
            cache2mem_command    = ch_command[gnt_idx];
            cache2mem_addr       = ch_addr[gnt_idx];
            ch_response[gnt_idx] = mem2cache_response;
            if (ch_command[gnt_idx] == BUS_STORE) cache2mem_data = ch_data[gnt_idx];
        end
        accepted = gnt_any && (mem2cache_response != '0);
        for (int i = 0; i < NUM_CH; i++) ch_reject[i] = req[i] & ~(ch_grant[i] & accepted);

        ret_hit  = (mem2cache_tag != '0) && valid_q[mem2cache_tag];
        ret_miss = (mem2cache_tag != '0) && !valid_q[mem2cache_tag];
        for (int i = 0; i < NUM_CH; i++) begin
            if (ret_hit && owner_q[mem2cache_tag] == CH_W'(i)) ch_tag[i] = mem2cache_tag;
        end

        // A tag freed and reallocated in the same cycle is a legal reuse, not a conflict.
        alloc          = accepted && (cache2mem_command == BUS_LOAD);
        alloc_conflict = alloc && valid_q[mem2cache_response]
                         && !(ret_hit && mem2cache_tag == mem2cache_response);

        valid_d = valid_q;
        owner_d = owner_q;
        if (ret_hit) valid_d[mem2cache_tag] = 1'b0;
        if (alloc) begin
            valid_d[mem2cache_response] = 1'b1;
            owner_d[mem2cache_response] = gnt_idx;
        end
    end

    always_comb begin
        outstanding = '0;
        for (int e = 0; e < ENTRIES; e++) outstanding = outstanding + (TAG_W + 1)'(valid_q[e]);
    end

    assign ch_rdata  = mem2cache_data;
    assign tag_error = tag_error_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q     <= '0;
            owner_q     <= '0;
            tag_error_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
            ptr_q       <= '0;
`endif
        end else begin
            valid_q     <= valid_d;
            owner_q     <= owner_d;
            tag_error_q <= ret_miss | alloc_conflict;
`ifdef MEM_ARB_RR_EN
            if (accepted) ptr_q <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter (NUM_CH=3, TAG_W=4); round-robin sequence runs when
// MEM_ARB_RR_EN is defined, a fixed-priority streaming sequence otherwise.
module tb_mem_arbiter;
    localparam int NUM_CH = 3;
    localparam int TAG_W  = 4;
    localparam int XLEN   = 64;
    localparam logic [1:0] BN = 2'd0;
    localparam logic [1:0] BL = 2'd1;
    localparam logic [1:0] BS = 2'd2;

    logic                         clock = 1'b0;
    logic                         reset = 1'b1;
    logic [NUM_CH-1:0][1:0]       ch_command;
    logic [NUM_CH-1:0][XLEN-1:0]  ch_addr;
    logic [NUM_CH-1:0][63:0]      ch_data;
    logic [NUM_CH-1:0]            ch_grant, ch_reject;
    logic [NUM_CH-1:0][TAG_W-1:0] ch_response, ch_tag;
    logic [63:0]                  ch_rdata;
    logic [XLEN-1:0]              cache2mem_addr;
    logic [1:0]                   cache2mem_command;
    logic [63:0]                  cache2mem_data;
    logic [TAG_W-1:0]             mem2cache_response, mem2cache_tag;
    logic [63:0]                  mem2cache_data;
    logic [TAG_W:0]               outstanding;
    logic                         tag_error;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.NUM_CH(NUM_CH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
        .clock              (clock),
        .reset              (reset),
        .ch_command         (ch_command),
        .ch_addr            (ch_addr),
        .ch_data            (ch_data),
        .ch_grant           (ch_grant),
        .ch_reject          (ch_reject),
        .ch_response        (ch_response),
        .ch_tag             (ch_tag),
        .ch_rdata           (ch_rdata),
        .cache2mem_addr     (cache2mem_addr),
        .cache2mem_command  (cache2mem_command),
        .cache2mem_data     (cache2mem_data),
        .mem2cache_response (mem2cache_response),
        .mem2cache_tag      (mem2cache_tag),
        .mem2cache_data     (mem2cache_data),
        .outstanding        (outstanding),
        .tag_error          (tag_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  c0, c1, c2;
        logic [3:0]  resp, rtag;
        logic        rst;
        logic [2:0]  grant, reject;
        logic [11:0] xresp, xtag;   // {ch2, ch1, ch0}
        logic [1:0]  mcmd;
        logic [63:0] maddr, mdata;
        logic [4:0]  outs;
        logic        err;
    } vec_t;

    vec_t tv[$];

    function automatic void add(input logic [1:0] c0, c1, c2, input logic [3:0] resp, rtag,
                                input logic rst, input logic [2:0] grant, reject,
                                input logic [11:0] xresp, xtag, input logic [1:0] mcmd,
                                input logic [63:0] maddr, mdata, input logic [4:0] outs,
                                input logic err);
        vec_t v;
        v.c0 = c0; v.c1 = c1; v.c2 = c2; v.resp = resp; v.rtag = rtag; v.rst = rst;
        v.grant = grant; v.reject = reject; v.xresp = xresp; v.xtag = xtag; v.mcmd = mcmd;
        v.maddr = maddr; v.mdata = mdata; v.outs = outs; v.err = err;
        tv.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] c0, c1, c2, input logic [3:0] resp, rtag,
                         input logic rst);
        ch_command[0] = c0;
        ch_command[1] = c1;
        ch_command[2] = c2;
        mem2cache_response = resp;
        mem2cache_tag      = rtag;
        reset              = rst;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        @(posedge clock);
        #1;
        drive(v.c0, v.c1, v.c2, v.resp, v.rtag, v.rst);
        mem2cache_data = 64'hDEAD_BEEF_0000_0000 | 64'(n);
        #3;
        check($sformatf("v%0d grant", n), 64'(ch_grant), 64'(v.grant));
        check($sformatf("v%0d reject", n), 64'(ch_reject), 64'(v.reject));
        check($sformatf("v%0d response", n), 64'(ch_response), 64'(v.xresp));
        check($sformatf("v%0d tag", n), 64'(ch_tag), 64'(v.xtag));
        check($sformatf("v%0d cmd", n), 64'(cache2mem_command), 64'(v.mcmd));
        check($sformatf("v%0d addr", n), cache2mem_addr, v.maddr);
        check($sformatf("v%0d wdata", n), cache2mem_data, v.mdata);
        check($sformatf("v%0d outstanding", n), 64'(outstanding), 64'(v.outs));
        check($sformatf("v%0d tag_error", n), 64'(tag_error), 64'(v.err));
        if (v.rtag != 4'd0)
            check($sformatf("v%0d rdata", n), ch_rdata, 64'hDEAD_BEEF_0000_0000 | 64'(n));
    endtask

    initial begin
        ch_addr[0] = 64'h1000; ch_addr[1] = 64'h2000; ch_addr[2] = 64'h3000;
        ch_data[0] = 64'hAAAA; ch_data[1] = 64'h1234; ch_data[2] = 64'hBBBB;
        drive(BN, BN, BN, 4'd0, 4'd0, 1'b1);
        mem2cache_data = '0;

        //  c0  c1  c2  rsp rtag rst grant rej  xresp   xtag    cmd addr     wdata    out err
        add(BN, BN, BN, 0, 0, 0, 3'b000, 3'b000, 12'h000, 12'h000, BN, 64'h0,    64'h0,    0, 0);
        add(BL, BL, BL, 5, 0, 0, 3'b001, 3'b110, 12'h005, 12'h000, BL, 64'h1000, 64'h0,    0, 0);
        add(BN, BL, BL, 0, 0, 0, 3'b010, 3'b110, 12'h000, 12'h000, BL, 64'h2000, 64'h0,    1, 0);
        add(BN, BN, BL, 6, 0, 0, 3'b100, 3'b000, 12'h600, 12'h000, BL, 64'h3000, 64'h0,    1, 0);
        add(BN, BN, BN, 0, 6, 0, 3'b000, 3'b000, 12'h000, 12'h600, BN, 64'h0,    64'h0,    2, 0);
        add(BN, BN, BN, 0, 0, 0, 3'b000, 3'b000, 12'h000, 12'h000, BN, 64'h0,    64'h0,    1, 0);
        add(BN, BS, BN, 3, 0, 0, 3'b010, 3'b000, 12'h030, 12'h000, BS, 64'h2000, 64'h1234, 1, 0);
        add(BN, BN, BN, 0, 0, 0, 3'b000, 3'b000, 12'h000, 12'h000, BN, 64'h0,    64'h0,    1, 0);
        for (int i = 0; i < 3; i++)
            add(BN, BL, BN, 0, 0, 0, 3'b010, 3'b010, 12'h000, 12'h000, BL, 64'h2000, 64'h0, 1, 0);
        add(BN, BN, BN, 0, 9, 0, 3'b000, 3'b000, 12'h000, 12'h000, BN, 64'h0,    64'h0,    1, 0);
        add(BN, BN, BN, 0, 0, 0, 3'b000, 3'b000, 12'h000, 12'h000, BN, 64'h0,    64'h0,    1, 1);
        add(BN, BN, BN, 0, 0, 0, 3'b000, 3'b000, 12'h000, 12'h000, BN, 64'h0,    64'h0,    1, 0);
        // Reallocating live tag 5 to ch2: flagged, new owner wins.
        add(BN, BN, BL, 5, 0, 0, 3'b100, 3'b000, 12'h500, 12'h000, BL, 64'h3000, 64'h0,    1, 0);
        add(BN, BN, BN, 0, 5, 0, 3'b000, 3'b000, 12'h000, 12'h500, BN, 64'h0,    64'h0,    1, 1);
        add(BN, BN, BN, 0, 0, 0, 3'b000, 3'b000, 12'h000, 12'h000, BN, 64'h0,    64'h0,    0, 0);
        // Same-cycle return and reallocation of tag 7.
        add(BL, BN, BN, 7, 0, 0, 3'b001, 3'b000, 12'h007, 12'h000, BL, 64'h1000, 64'h0,    0, 0);
        add(BN, BL, BN, 7, 7, 0, 3'b010, 3'b000, 12'h070, 12'h007, BL, 64'h2000, 64'h0,    1, 0);
        add(BN, BN, BN, 0, 7, 0, 3'b000, 3'b000, 12'h000, 12'h070, BN, 64'h0,    64'h0,    1, 0);
        add(BN, BN, BN, 0, 0, 0, 3'b000, 3'b000, 12'h000, 12'h000, BN, 64'h0,    64'h0,    0, 0);
        // Reset with tags 5 and 6 outstanding, then a stale return of tag 5.
        add(BL, BN, BN, 5, 0, 0, 3'b001, 3'b000, 12'h005, 12'h000, BL, 64'h1000, 64'h0,    0, 0);
        add(BL, BN, BN, 6, 0, 0, 3'b001, 3'b000, 12'h006, 12'h000, BL, 64'h1000, 64'h0,    1, 0);
        add(BN, BN, BN, 0, 0, 1, 3'b000, 3'b000, 12'h000, 12'h000, BN, 64'h0,    64'h0,    2, 0);
        add(BN, BN, BN, 0, 0, 0, 3'b000, 3'b000, 12'h000, 12'h000, BN, 64'h0,    64'h0,    0, 0);
        add(BN, BN, BN, 0, 5, 0, 3'b000, 3'b000, 12'h000, 12'h000, BN, 64'h0,    64'h0,    0, 0);
        add(BN, BN, BN, 0, 0, 0, 3'b000, 3'b000, 12'h000, 12'h000, BN, 64'h0,    64'h0,    0, 1);

        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        foreach (tv[n]) run_vec(tv[n], n);

`ifdef MEM_ARB_RR_EN
        // Pointer is 0 after reset: all three request, every request accepted.
        begin
            logic [2:0] exp_g [4];
            exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
            for (int k = 0; k < 4; k++) begin
                @(posedge clock); #1;
                drive(BL, BL, BL, 4'(k + 1), 4'd0, 1'b0);
                #3;
                check($sformatf("rr%0d grant", k), 64'(ch_grant), 64'(exp_g[k]));
                check($sformatf("rr%0d reject", k), 64'(ch_reject), 64'(~exp_g[k]));
            end
            // Busy memory must not rotate the pointer (now at ch1).
            for (int k = 0; k < 3; k++) begin
                @(posedge clock); #1;
                drive(BL, BL, BL, 4'd0, 4'd0, 1'b0);
                #3;
                check($sformatf("rr busy%0d grant", k), 64'(ch_grant), 64'(3'b010));
                check($sformatf("rr busy%0d reject", k), 64'(ch_reject), 64'(3'b111));
            end
            @(posedge clock); #1;
            drive(BN, BN, BN, 4'd0, 4'd0, 1'b0);
            #3;
            check("rr outstanding", 64'(outstanding), 64'd4);
        end
`else
        // Continuous contention with every request accepted: ch0 always wins.
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            drive(BL, BL, BL, 4'(k + 1), 4'd0, 1'b0);
            #3;
            check($sformatf("fp%0d grant", k), 64'(ch_grant), 64'(3'b001));
            check($sformatf("fp%0d response", k), 64'(ch_response), 64'(k + 1));
        end
        @(posedge clock); #1;
        drive(BN, BN, BN, 4'd0, 4'd0, 1'b0);
        #3;
        check("fp outstanding", 64'(outstanding), 64'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
